// File: rtl/mul_pkg.sv
// Shared definitions for the M-extension multiply path: funct3 decode,
// multiplier operand-signedness encodings and the issued micro-op record.
package mul_pkg;

  localparam int MUL_XLEN      = 32;
  localparam int MUL_ROB_IDX_W = 5;
  localparam int MUL_PREG_W    = 6;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    MT_UU = 2'b00,
    MT_SS = 2'b01,
    MT_SU = 2'b10
  } mul_type_e;

  typedef struct packed {
    logic [2:0]               funct3;
    logic [MUL_XLEN-1:0]      rs1;
    logic [MUL_XLEN-1:0]      rs2;
    logic [MUL_ROB_IDX_W-1:0] rob_idx;
    logic [MUL_PREG_W-1:0]    pd;
  } mul_uop_t;

  // MUL keeps only the low word, which is identical for any signedness.
  function automatic mul_type_e funct3_to_mul_type(input logic [2:0] f3);
    case (f3)
      F3_MULH:   return MT_SS;
      F3_MULHSU: return MT_SU;
      default:   return MT_UU;
    endcase
  endfunction

endpackage

// File: rtl/mul_fu_ctrl_if.sv
// Issue and CDB channels of the multiply functional unit.
// Both channels use valid/ready: a transfer happens on a clock edge where
// valid && ready; once raised, valid and its payload hold until that edge.
interface mul_fu_ctrl_if
  import mul_pkg::*;
#(
  parameter int XLEN      = MUL_XLEN,
  parameter int ROB_IDX_W = MUL_ROB_IDX_W,
  parameter int PREG_W    = MUL_PREG_W
);
  logic                 iss_valid;
  logic                 iss_ready;
  logic [2:0]           iss_funct3;
  logic [XLEN-1:0]      iss_rs1;
  logic [XLEN-1:0]      iss_rs2;
  logic [ROB_IDX_W-1:0] iss_rob_idx;
  logic [PREG_W-1:0]    iss_pd;

  logic                 cdb_valid;
  logic                 cdb_ready;
  logic [XLEN-1:0]      cdb_data;
  logic [ROB_IDX_W-1:0] cdb_rob_idx;
  logic [PREG_W-1:0]    cdb_pd;

  modport slave (
    input  iss_valid, iss_funct3, iss_rs1, iss_rs2, iss_rob_idx, iss_pd, cdb_ready,
    output iss_ready, cdb_valid, cdb_data, cdb_rob_idx, cdb_pd
  );

  modport master (
    output iss_valid, iss_funct3, iss_rs1, iss_rs2, iss_rob_idx, iss_pd, cdb_ready,
    input  iss_ready, cdb_valid, cdb_data, cdb_rob_idx, cdb_pd
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle over the
// sign-extended 2*W-bit operands; done holds until start is released.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [OPERAND_WIDTH-1:0]   a,
  input  logic [OPERAND_WIDTH-1:0]   b,
  input  logic [1:0]                 mul_type,
  output logic                       done,
  output logic [2*OPERAND_WIDTH-1:0] p,
  output logic [1:0]                 dbg_state_o
);
  localparam int PW = 2 * OPERAND_WIDTH;
  localparam int CW = $clog2(PW);

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_CALC = 2'd1,
    M_DONE = 2'd2
  } mstate_e;

  mstate_e       state_q, state_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [PW-1:0] mplier_q, mplier_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_signed, b_signed;

  assign a_signed = (mul_type == MT_SS) || (mul_type == MT_SU);
  assign b_signed = (mul_type == MT_SS);

  // Product of sign-extended operands modulo 2^PW is the exact signed product.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done     = 1'b0;
    case (state_q)
      M_IDLE: begin
        if (start) begin
          mcand_d  = {{OPERAND_WIDTH{a_signed & a[OPERAND_WIDTH-1]}}, a};
          mplier_d = {{OPERAND_WIDTH{b_signed & b[OPERAND_WIDTH-1]}}, b};
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = M_CALC;
        end
      end
      M_CALC: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(PW - 1)) state_d = M_DONE;
      end
      M_DONE: begin
        done = 1'b1;
        if (!start) state_d = M_IDLE;
      end
      default: state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= M_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign p           = acc_q;
  assign dbg_state_o = state_q;

endmodule

// File: rtl/mul_fu_ctrl.sv
// Multiply functional-unit controller: accepts one M-extension op, runs the
// shift-add multiplier (or bypasses it on a zero operand), and holds the result for the CDB.
module mul_fu_ctrl
  import mul_pkg::*;
#(
  parameter int XLEN      = MUL_XLEN,
  parameter int ROB_IDX_W = MUL_ROB_IDX_W,
  parameter int PREG_W    = MUL_PREG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  mul_fu_ctrl_if.slave     bus,
  output logic [1:0]       dbg_state_o,
  output logic [1:0]       dbg_mul_state_o,
  output logic             dbg_mul_start_o
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  mul_uop_t          uop_q, uop_d, iss_uop;
  mul_type_e         mtype_q, mtype_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              mul_start, mul_done;
  logic [2*XLEN-1:0] mul_p;
  logic              iss_ok;

  always_comb begin
    iss_uop.funct3  = bus.iss_funct3;
    iss_uop.rs1     = MUL_XLEN'(bus.iss_rs1);
    iss_uop.rs2     = MUL_XLEN'(bus.iss_rs2);
    iss_uop.rob_idx = MUL_ROB_IDX_W'(bus.iss_rob_idx);
    iss_uop.pd      = MUL_PREG_W'(bus.iss_pd);
  end

  always_comb begin
    state_d       = state_q;
    uop_d         = uop_q;
    mtype_d       = mtype_q;
    data_d        = data_q;
    iss_ok        = 1'b0;
    bus.iss_ready = 1'b0;
    bus.cdb_valid = 1'b0;
    mul_start     = 1'b0;
    unique case (state_q)
      IDLE: begin
        iss_ok        = rst_n && !flush;
        bus.iss_ready = iss_ok;
        if (bus.iss_valid && iss_ok) begin
          uop_d   = iss_uop;
          mtype_d = funct3_to_mul_type(bus.iss_funct3);
          data_d  = '0;
          state_d = (bus.iss_rs1 == '0 || bus.iss_rs2 == '0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        mul_start = 1'b1;
        if (mul_done) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            data_d  = (uop_q.funct3 == F3_MUL) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
            state_d = RESP;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      // The multiplier cannot be aborted, so a killed op keeps start high until done.
      DRAIN: begin
        mul_start = 1'b1;
        if (mul_done) state_d = IDLE;
      end
      RESP: begin
        bus.cdb_valid = !flush;
        if (flush || bus.cdb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      uop_q   <= '0;
      mtype_q <= MT_UU;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      uop_q   <= uop_d;
      mtype_q <= mtype_d;
      data_q  <= data_d;
    end
  end

  shift_add_multiplier #(
    .OPERAND_WIDTH (XLEN)
  ) u_mul (
    .clk         (clk),
    .rst         (!rst_n),
    .start       (mul_start),
    .a           (XLEN'(uop_q.rs1)),
    .b           (XLEN'(uop_q.rs2)),
    .mul_type    (mtype_q),
    .done        (mul_done),
    .p           (mul_p),
    .dbg_state_o (dbg_mul_state_o)
  );

  assign bus.cdb_data    = data_q;
  assign bus.cdb_rob_idx = ROB_IDX_W'(uop_q.rob_idx);
  assign bus.cdb_pd      = PREG_W'(uop_q.pd);

  assign dbg_state_o     = state_q;
  assign dbg_mul_start_o = mul_start;

  a_legal_funct3: assert property (@(posedge clk) disable iff (!rst_n)
    bus.iss_valid |-> !bus.iss_funct3[2]);

  a_no_cdb_in_drain: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == DRAIN) |-> !bus.cdb_valid);

  a_start_held: assert property (@(posedge clk) disable iff (!rst_n)
    (mul_start && !mul_done) |=> mul_start);

  a_cdb_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.cdb_valid && !bus.cdb_ready) |=>
      ($stable(bus.cdb_data) && $stable(bus.cdb_rob_idx) && $stable(bus.cdb_pd)));

endmodule

// File: tb/tb_mul_fu_ctrl.sv
// Bench for mul_fu_ctrl: vector table, hand-written flush/reset/back-pressure
// sequences and randomized ops checked against a plain-arithmetic model.
module tb_mul_fu_ctrl;
  import mul_pkg::*;

  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = 5;
  localparam int PREG_W    = 6;
  localparam int LAT_MUL   = 2 * XLEN + 3;
  localparam int TIMEOUT   = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] dbg_state, dbg_mul_state;
  logic       dbg_mul_start;

  mul_fu_ctrl_if #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .PREG_W(PREG_W)) bus ();

  mul_fu_ctrl #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .PREG_W(PREG_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .bus             (bus),
    .dbg_state_o     (dbg_state),
    .dbg_mul_state_o (dbg_mul_state),
    .dbg_mul_start_o (dbg_mul_start)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int              n_checks = 0;
  int              n_errors = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: full 64-bit product of the operands as the op interprets them.
  function automatic logic [XLEN-1:0] ref_mul(input logic [2:0] f3,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [63:0] ua, ub, sa, sb, prod;
    ua = {32'h0, a};
    ub = {32'h0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (f3)
      F3_MUL:    prod = ua * ub;
      F3_MULH:   prod = sa * sb;
      F3_MULHSU: prod = sa * ub;
      default:   prod = ua * ub;
    endcase
    return (f3 == F3_MUL) ? prod[31:0] : prod[63:32];
  endfunction

  // ---------------- driver ----------------
  // Called and returns at a falling edge; hold = cycles cdb_ready stays low once valid.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_data, input int hold);
    logic [ROB_IDX_W-1:0] rob;
    logic [PREG_W-1:0]    pd;
    logic [XLEN-1:0]      exp;
    int                   lat, waited, exp_lat;
    logic                 seen_start;
    rob = ROB_IDX_W'($urandom);
    pd  = PREG_W'($urandom);
    exp_q.push_back(exp_data);
    exp_lat = (a == '0 || b == '0) ? 1 : LAT_MUL;
    waited = 0;
    while (!bus.iss_ready && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.iss_ready) begin
      check({tag, " iss_ready timeout"}, bus.iss_ready, 1);
      void'(exp_q.pop_front());
      return;
    end
    bus.iss_valid   = 1'b1;
    bus.iss_funct3  = f3;
    bus.iss_rs1     = a;
    bus.iss_rs2     = b;
    bus.iss_rob_idx = rob;
    bus.iss_pd      = pd;
    bus.cdb_ready   = (hold == 0);
    @(negedge clk);
    bus.iss_valid = 1'b0;
    lat = 1;
    seen_start = 1'b0;
    while (!bus.cdb_valid && lat < TIMEOUT) begin
      seen_start |= dbg_mul_start;
      @(negedge clk);
      lat++;
    end
    seen_start |= dbg_mul_start;
    exp = exp_q.pop_front();
    check({tag, " cdb_valid"}, bus.cdb_valid, 1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " cdb_data"}, bus.cdb_data, exp);
    check({tag, " cdb_rob_idx"}, bus.cdb_rob_idx, rob);
    check({tag, " cdb_pd"}, bus.cdb_pd, pd);
    if (exp_lat == 1) check({tag, " no multiplier start"}, seen_start, 0);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      check({tag, " held valid"}, bus.cdb_valid, 1);
      check({tag, " held data"}, {bus.cdb_data, bus.cdb_rob_idx, bus.cdb_pd}, {exp, rob, pd});
    end
    bus.cdb_ready = 1'b1;
    @(negedge clk);
    check({tag, " valid drops after accept"}, bus.cdb_valid, 0);
    check({tag, " ready after accept"}, bus.iss_ready, 1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    string           name;
    logic [2:0]      f3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    int              hold;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat;
    logic seen_valid;
    logic [2:0] f3;
    logic [XLEN-1:0] ra, rb;

    vecs[0] = '{"mul_7x6",      F3_MUL,    32'd7,         32'd6,         32'd42,        0};
    vecs[1] = '{"mulh_m2x3",    F3_MULH,   32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  0};
    vecs[2] = '{"mulhu_m2x3",   F3_MULHU,  32'hFFFFFFFE,  32'd3,         32'h00000002,  0};
    vecs[3] = '{"mulhsu_m1",    F3_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,  0};
    vecs[4] = '{"mul_zero",     F3_MUL,    32'd0,         32'h1234,      32'd0,         0};
    vecs[5] = '{"mulh_minsq",   F3_MULH,   32'h80000000,  32'h80000000,  32'h40000000,  0};
    vecs[6] = '{"mul_m1sq",     F3_MUL,    32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  0};
    vecs[7] = '{"mulhu_zero_b", F3_MULHU,  32'hDEADBEEF,  32'd0,         32'd0,         2};
    vecs[8] = '{"mul_hold5",    F3_MUL,    32'h1234,      32'h10,        32'h12340,     5};
    vecs[9] = '{"b2b_after",    F3_MULHU,  32'h10000,     32'h30000,     32'h00000003,  0};

    bus.iss_valid   = 1'b0;
    bus.iss_funct3  = 3'b000;
    bus.iss_rs1     = '0;
    bus.iss_rs2     = '0;
    bus.iss_rob_idx = '0;
    bus.iss_pd      = '0;
    bus.cdb_ready   = 1'b0;

    repeat (2) @(negedge clk);
    check("reset cdb_valid", bus.cdb_valid, 0);
    check("reset iss_ready", bus.iss_ready, 0);
    check("reset cdb_fields", {bus.cdb_data, bus.cdb_rob_idx, bus.cdb_pd}, 0);
    check("reset start", dbg_mul_start, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset iss_ready", bus.iss_ready, 1);

    foreach (vecs[i]) do_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold);

    // Flush at cycle 10 of an in-flight op: no result, unit busy until multiplier done.
    bus.cdb_ready   = 1'b1;
    bus.iss_valid   = 1'b1;
    bus.iss_funct3  = F3_MUL;
    bus.iss_rs1     = 32'd5;
    bus.iss_rs2     = 32'd5;
    bus.iss_rob_idx = 5'd3;
    bus.iss_pd      = 6'd9;
    @(negedge clk);
    bus.iss_valid = 1'b0;
    lat = 1;
    seen_valid = 1'b0;
    while (lat < TIMEOUT) begin
      if (bus.cdb_valid) seen_valid = 1'b1;
      if (bus.iss_ready) break;
      flush = (lat == 10);
      @(negedge clk);
      lat++;
    end
    flush = 1'b0;
    check("flush no cdb_valid", seen_valid, 0);
    check("flush iss_ready return cycle", lat, LAT_MUL);
    do_op("after_flush", F3_MUL, 32'd3, 32'd4, 32'd12, 0);

    // Reset asserted while the multiplier is running.
    bus.iss_valid  = 1'b1;
    bus.iss_funct3 = F3_MULH;
    bus.iss_rs1    = 32'd9;
    bus.iss_rs2    = 32'd9;
    @(negedge clk);
    bus.iss_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("busy before reset", bus.iss_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid-busy reset cdb_valid", bus.cdb_valid, 0);
    check("mid-busy reset iss_ready", bus.iss_ready, 0);
    check("mid-busy reset start", dbg_mul_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after reset iss_ready", bus.iss_ready, 1);
    do_op("post_reset_mulhu", F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);

    // Randomized ops against the reference model.
    for (int n = 0; n < 16; n++) begin
      f3 = 3'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       ra = '0;
        1:       ra = 32'hFFFFFFFF;
        2:       ra = 32'h80000000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'h7FFFFFFF;
        default: rb = $urandom;
      endcase
      do_op($sformatf("rand%0d", n), f3, ra, rb, ref_mul(f3, ra, rb), $urandom_range(0, 3));
    end

    check("scoreboard empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
